// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM state codes, byte-lane table and lane helpers for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] addr);
    return size == SZ_BYTE ? addr : size == SZ_HALF ? {addr[1], 1'b0} : 2'b00;
  endfunction
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_WORD ? BE_WORD : (size == SZ_HALF ? BE_HALF : BE_BYTE) << off;
  endfunction
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] w);
    return size == SZ_BYTE ? {4{w[7:0]}} : size == SZ_HALF ? {2{w[15:0]}} : w;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed lane of rdata (size, off) and sign/zero-extends it into data
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  off,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = rdata >> {off, 3'b000};
  assign data = size == SZ_BYTE ? {{24{sign_ext & sh[7]}}, sh[7:0]} :
                size == SZ_HALF ? {{16{sign_ext & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: IDLE/ACCESS/DONE load-store FSM; req_* in from execute, dm_* to data memory, busy/done/load_data/lsu_err out; LSU_MISALIGN_CHECK_EN turns misaligned half/word into errors
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic        req_addr_ovf,
  input  logic [31:0] req_wdata,
  output logic        dm_enable,
  output logic        dm_write,
  output logic [31:0] dm_address,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byte_en,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        lsu_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [1:0] state, size_q, off_q;
  logic write_q, signed_q, mis, err;
  logic [29:0] word_q;
  logic [31:0] wdata_q, aligned;
  logic [CW-1:0] cnt;
`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign err = req_addr_ovf || req_size == SZ_RSVD || mis;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  assign dm_enable = state == ST_ACCESS;
  assign dm_write = dm_enable & write_q;
  assign dm_address = {word_q, 2'b00};
  assign dm_wdata = replicate(size_q, wdata_q);
  assign dm_byte_en = dm_enable ? lane_en(size_q, off_q) : 4'b0000;
  lsu_load_align u_align (
    .rdata(dm_rdata),
    .size(size_q),
    .sign_ext(signed_q),
    .off(off_q),
    .data(aligned)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      size_q <= 2'b00;
      off_q <= 2'b00;
      write_q <= 1'b0;
      signed_q <= 1'b0;
      word_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      load_data <= '0;
      lsu_err <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (req_valid) begin
        size_q <= req_size;
        off_q <= lane_off(req_size, req_addr[1:0]);
        write_q <= req_write;
        signed_q <= req_signed;
        word_q <= req_addr[31:2];
        wdata_q <= req_wdata;
        cnt <= '0;
        state <= err ? ST_DONE : ST_ACCESS;
        if (err) lsu_err <= 1'b1;
      end
    end else if (state == ST_ACCESS) begin
      if (dm_ready) begin
        state <= ST_DONE;
        lsu_err <= 1'b0;
        if (!write_q) load_data <= aligned;
      end else if (cnt == LAST) begin
        state <= ST_DONE;
        lsu_err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for dm_ready before aborting.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  one-cycle request strobe from the execute stage.
REQ-005 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port req_signed  input  1  sign-extend (1) or zero-extend (0) load data.
REQ-008 SHALL have port req_addr  input  32  effective address, i.e. the ALU sum.
REQ-009 SHALL have port req_addr_ovf  input  1  ALU overflow flag for req_addr.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have memory-side ports: dm_enable out 1, dm_write out 1, dm_address out 32, dm_wdata out 32, dm_byte_en out 4, dm_ready in 1, dm_rdata in 32.
REQ-012 SHALL have pipeline-side outputs: busy 1, done 1, load_data 32, lsu_err 1.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: accept req_valid; latch all req_* fields.
- ACCESS: hold dm_* stable until dm_ready.
- DONE: single-cycle state.
REQ-014 SHALL go IDLE->ACCESS on req_valid when no error is detected; an error request SHALL go directly to DONE with lsu_err=1 and no dm_enable.
REQ-015 SHALL ignore req_valid while busy=1; busy SHALL be 1 in ACCESS and DONE.
REQ-016 SHALL in ACCESS drive dm_enable=1, dm_write=latched req_write, dm_address={addr[31:2],2'b00}.
REQ-017 SHALL use little-endian byte lanes for dm_byte_en.
- Byte: 0001<<addr[1:0].
- Half: 0011<<addr[1:0].
- Word: 1111.
REQ-018 SHALL replicate store data across lanes: byte {4{b}}, half {2{h}}, word as is.
REQ-019 SHALL leave ACCESS on the cycle dm_ready=1 is sampled; latency from req_valid to done SHALL be N+2 cycles, where N is the count of ACCESS cycles with dm_ready=0.
REQ-020 SHALL count ACCESS cycles with a wait counter; when it reaches TIMEOUT_CYCLES without dm_ready, it SHALL abort to DONE with lsu_err=1.
REQ-021 SHALL in DONE pulse done=1 for exactly one cycle; load_data and lsu_err SHALL hold until the next request completes.
REQ-022 SHALL extract load_data from dm_rdata by lane addr[1:0], then sign- or zero-extend per req_signed; word loads SHALL pass through unchanged; stores SHALL leave load_data unchanged.
REQ-023 SHALL treat req_addr_ovf=1 or req_size=11 as an error.
REQ-024 SHALL drive dm_enable=0, dm_byte_en=0 outside ACCESS; dm_ready outside ACCESS SHALL be ignored.

Reset
REQ-025 SHALL on reset (asynchronous) enter IDLE, clear the wait counter, and drive busy, done, lsu_err, dm_enable and dm_write to 0 and load_data, dm_address, dm_wdata and dm_byte_en to 0; a reset during ACCESS SHALL abandon the access with no done pulse.

Configuration
REQ-026 SHALL honour macro LSU_MISALIGN_CHECK_EN.
- Defined: a half at addr[0]=1 or a word at addr[1:0]!=0 SHALL be an error (REQ-014 path).
- Undefined: misaligned low address bits SHALL be ignored, forcing natural alignment with no error.

Structure
REQ-027 SHALL place size encodings, FSM state encodings and the byte-lane table constants in shared package lsu_pkg.
REQ-028 SHALL place load lane extraction and extension in sub-module lsu_load_align (combinational).

Verification
REQ-029 SHALL cover a word load: addr 0x100, dm_ready after 2 waits, rdata 0xDEADBEEF -> done at cycle 4, load_data 0xDEADBEEF, lsu_err 0.
REQ-030 SHALL cover a signed byte load: addr 0x103, rdata 0x80112233 -> byte_en 1000, load_data 0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-031 SHALL cover a half store: addr 0x102, wdata 0x0000ABCD -> byte_en 1100, dm_wdata 0xABCDABCD, dm_address 0x100.
REQ-032 SHALL cover timeout: dm_ready held 0 -> abort after 16 ACCESS cycles, done=1, lsu_err=1.
REQ-033 SHALL cover a misaligned word at 0x101 -> with LSU_MISALIGN_CHECK_EN: done, lsu_err=1, no dm_enable; without it: access at 0x100 with byte_en 1111.
REQ-034 SHALL cover reset asserted mid-ACCESS -> outputs 0 immediately, no done; a new request after reset completes normally.
